axisprbs_check: RTL and testbench

Self-synchronizing AXI-stream checker for the 32-bit PRBS produced by the team's `axisrandom` generator. It sits directly downstream of that generator, usually across a link or FIFO under test. It consumes every beat and locks onto the sequence. Once locked, it flags and counts each beat that departs from the expected sequence.

---
 rtl/axisprbs_check.sv | 118 +++++++++++
 tb/tb_axisprbs_check.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/axisprbs_check.sv
// Self-synchronizing checker for the 32-bit axisrandom PRBS: hunts for lock, then counts mismatches.
// Define AXISPRBSCHK_SATURATE_EN to make both counters saturate at all-ones instead of wrapping.
module axisprbs_check #(
  parameter int LGCOUNT    = 32,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESET,
  input  logic               S_AXIS_TVALID,
  output logic               S_AXIS_TREADY,
  input  logic [31:0]        S_AXIS_TDATA,
  input  logic               i_clear,
  output logic               o_locked,
  output logic               o_err,
  output logic [LGCOUNT-1:0] o_err_count,
  output logic [LGCOUNT-1:0] o_beat_count
);

  localparam int RUN_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int RW      = (RUN_MAX < 2) ? 1 : $clog2(RUN_MAX + 1);
  localparam logic [RW-1:0] LOCK_RUN = RW'(LOCK_COUNT);
  localparam logic [RW-1:0] LOSS_RUN = RW'(LOSS_COUNT);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t             state_reg;
  logic [31:0]        ref_reg;
  logic               have_ref_reg;
  logic [RW-1:0]      run_reg;
  logic               tready_reg;
  logic               err_reg;
  logic [LGCOUNT-1:0] err_count_reg;
  logic [LGCOUNT-1:0] beat_count_reg;

  logic               beat;
  logic               data_eq;
  logic [31:0]        ref_from_data;
  logic [31:0]        ref_from_ref;
  logic [RW-1:0]      run_inc;
  logic [LGCOUNT-1:0] err_count_next;
  logic [LGCOUNT-1:0] beat_count_next;

  assign beat          = S_AXIS_TVALID && tready_reg;
  assign data_eq       = (S_AXIS_TDATA == ref_reg);
  assign ref_from_data = {S_AXIS_TDATA[14] ^ S_AXIS_TDATA[1], S_AXIS_TDATA[31:1]};
  assign ref_from_ref  = {ref_reg[14] ^ ref_reg[1], ref_reg[31:1]};
  assign run_inc       = run_reg + RW'(1);

`ifdef AXISPRBSCHK_SATURATE_EN
  assign err_count_next  = (&err_count_reg)  ? err_count_reg  : err_count_reg  + LGCOUNT'(1);
  assign beat_count_next = (&beat_count_reg) ? beat_count_reg : beat_count_reg + LGCOUNT'(1);
`else
  assign err_count_next  = err_count_reg  + LGCOUNT'(1);
  assign beat_count_next = beat_count_reg + LGCOUNT'(1);
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_reg      <= HUNT;
      ref_reg        <= '0;
      have_ref_reg   <= 1'b0;
      run_reg        <= '0;
      tready_reg     <= 1'b0;
      err_reg        <= 1'b0;
      err_count_reg  <= '0;
      beat_count_reg <= '0;
    end else begin
      tready_reg <= 1'b1;
      err_reg    <= 1'b0;
      if (beat) begin
        beat_count_reg <= beat_count_next;
        if (state_reg == HUNT) begin
          // While hunting, every beat reseeds the reference from the data itself.
          ref_reg      <= ref_from_data;
          have_ref_reg <= 1'b1;
          if (have_ref_reg && data_eq) begin
            if (run_inc == LOCK_RUN) begin
              state_reg <= LOCKED;
              run_reg   <= '0;
            end else begin
              run_reg <= run_inc;
            end
          end else begin
            run_reg <= '0;
          end
        end else begin
          // Free-running reference: a single corrupted beat costs exactly one error.
          ref_reg <= ref_from_ref;
          if (data_eq) begin
            run_reg <= '0;
          end else begin
            err_reg       <= 1'b1;
            err_count_reg <= err_count_next;
            if (run_inc == LOSS_RUN) begin
              state_reg    <= HUNT;
              run_reg      <= '0;
              have_ref_reg <= 1'b0;
            end else begin
              run_reg <= run_inc;
            end
          end
        end
      end
      if (i_clear) begin
        err_count_reg  <= '0;
        beat_count_reg <= '0;
      end
    end
  end

  assign S_AXIS_TREADY = tready_reg;
  assign o_locked      = (state_reg == LOCKED);
  assign o_err         = err_reg;
  assign o_err_count   = err_count_reg;
  assign o_beat_count  = beat_count_reg;

endmodule

// File: tb/tb_axisprbs_check.sv
// Directed bench for axisprbs_check: table of per-cycle vectors plus reset, random-valid and small-counter sequences.
module tb_axisprbs_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tvalid, clear, tvalid2;
  logic [31:0] tdata;
  logic        tready, locked, err;
  logic [31:0] ec, bc;
  logic        tready2, locked2, err2;
  logic [2:0]  ec2, bc2;

  axisprbs_check #(.LGCOUNT(32), .LOCK_COUNT(4), .LOSS_COUNT(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready),
    .S_AXIS_TDATA(tdata), .i_clear(clear), .o_locked(locked), .o_err(err),
    .o_err_count(ec), .o_beat_count(bc));

  axisprbs_check #(.LGCOUNT(3), .LOCK_COUNT(4), .LOSS_COUNT(4)) dut_small (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .S_AXIS_TVALID(tvalid2), .S_AXIS_TREADY(tready2),
    .S_AXIS_TDATA(tdata), .i_clear(1'b0), .o_locked(locked2), .o_err(err2),
    .o_err_count(ec2), .o_beat_count(bc2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen_next(input logic [31:0] d);
    return {d[14] ^ d[1], d[31:1]};
  endfunction

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        clr;
    logic        locked;
    logic        err;
    logic [31:0] ec;
    logic [31:0] bc;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] s[0:31];

  task automatic add(input logic v, input logic [31:0] d, input logic clr, input logic lk,
                     input logic e, input logic [31:0] xec, input logic [31:0] xbc);
    vec_t r;
    r.v = v; r.d = d; r.clr = clr; r.locked = lk; r.err = e; r.ec = xec; r.bc = xbc;
    vt.push_back(r);
  endtask

  initial begin
    int nb;
    logic [31:0] cur;
    logic [31:0] exp_sat;

    s[0] = 32'h8000_0000;
    for (int k = 1; k < 32; k++) s[k] = gen_next(s[k-1]);

    // Acquire lock on a clean stream: lock visible after the 5th beat.
    add(1, s[0], 0, 0, 0, 0, 1);
    add(1, s[1], 0, 0, 0, 0, 2);
    add(1, s[2], 0, 0, 0, 0, 3);
    add(1, s[3], 0, 0, 0, 0, 4);
    add(1, s[4], 0, 1, 0, 0, 5);
    add(1, s[5], 0, 1, 0, 0, 6);
    // Single corrupted beat, then clean again.
    add(1, s[6] ^ 32'h1, 0, 1, 1, 1, 7);
    add(1, s[7], 0, 1, 0, 1, 8);
    add(1, s[8], 0, 1, 0, 1, 9);
    // Idle clear, then four zero beats drop lock.
    add(0, s[9], 1, 1, 0, 0, 0);
    add(1, 32'h0, 0, 1, 1, 1, 1);
    add(1, 32'h0, 0, 1, 1, 2, 2);
    add(1, 32'h0, 0, 1, 1, 3, 3);
    add(1, 32'h0, 0, 0, 1, 4, 4);
    // Relock needs 5 beats; an idle cycle in between changes nothing.
    add(1, s[13], 0, 0, 0, 4, 5);
    add(1, s[14], 0, 0, 0, 4, 6);
    add(0, 32'hdead_beef, 0, 0, 0, 4, 6);
    add(1, s[15], 0, 0, 0, 4, 7);
    add(1, s[16], 0, 0, 0, 4, 8);
    add(1, s[17], 0, 1, 0, 4, 9);
    // Clear coinciding with a mismatching beat: counters zero, err still pulses.
    add(1, s[18] ^ 32'h0000_ffff, 1, 1, 1, 0, 0);
    add(1, s[19], 0, 1, 0, 0, 1);
    add(0, s[20], 0, 1, 0, 0, 1);

    rst = 1'b1; tvalid = 1'b0; clear = 1'b0; tvalid2 = 1'b0; tdata = '0;
    repeat (3) step();
    chk("reset.tready", tready, 0);
    chk("reset.locked", locked, 0);
    chk("reset.err", err, 0);
    chk("reset.err_count", ec, 0);
    chk("reset.beat_count", bc, 0);
    rst = 1'b0;
    step();
    chk("post_reset.tready", tready, 1);

    foreach (vt[i]) begin
      tvalid = vt[i].v; tdata = vt[i].d; clear = vt[i].clr;
      step();
      chk($sformatf("vec%0d.locked", i), locked, vt[i].locked);
      chk($sformatf("vec%0d.err", i), err, vt[i].err);
      chk($sformatf("vec%0d.err_count", i), ec, vt[i].ec);
      chk($sformatf("vec%0d.beat_count", i), bc, vt[i].bc);
    end
    tvalid = 1'b0; clear = 1'b0;

    // Mid-stream reset abandons lock.
    rst = 1'b1;
    step();
    chk("midreset.locked", locked, 0);
    chk("midreset.tready", tready, 0);
    chk("midreset.beat_count", bc, 0);
    rst = 1'b0;
    step();
    chk("midreset.tready_up", tready, 1);

    // Random 50% TVALID on a clean stream.
    nb = 0;
    cur = s[21];
    for (int c = 0; c < 400 && nb < 16; c++) begin
      tvalid = 1'($urandom_range(0, 1));
      tdata = tvalid ? cur : 32'h1234_5678;
      step();
      chk($sformatf("rand%0d.err", c), err, 0);
      if (tvalid) begin
        nb++;
        cur = gen_next(cur);
      end
    end
    tvalid = 1'b0;
    chk("rand.enough_beats", 32'(nb >= 16), 1);
    step();
    chk("rand.locked", locked, 1);
    chk("rand.err_count", ec, 0);
    chk("rand.beat_count", bc, nb);

    // Small counter: 9 beats into a 3-bit beat counter.
`ifdef AXISPRBSCHK_SATURATE_EN
    exp_sat = 32'h1;
`else
    exp_sat = 32'h0;
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    tvalid2 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tdata = s[i];
      step();
      if (i == 7) chk("small.beat_count7", bc2, 7);
      if (i == 8) chk("small.beat_count8", bc2, exp_sat ? 32'd7 : 32'd0);
      if (i == 9) chk("small.beat_count9", bc2, exp_sat ? 32'd7 : 32'd1);
    end
    tvalid2 = 1'b0;
    step();
    chk("small.hold", bc2, exp_sat ? 32'd7 : 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
